// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment bit order, active-low code table
// and the all-off pattern used by the display bank.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  // Active-low codes, entry n is the glyph for hex digit n (bit0 = a ... bit6 = g).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam seg_t SEG_BLANK_AL = 7'b1111111;

endpackage

// File: rtl/seven_seg_bank_hex_to_seg.sv
// Combinational nibble to seven-segment decoder; polarity chosen by ACTIVE_LOW.
module hex_to_seg
  import seven_seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = (ACTIVE_LOW != 0) ? SEG_TABLE[nibble] : ~SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_bank.sv
// Multi-digit hex display driver: load register, registered per-digit decode
// with leading-zero blanking and blink, plus a registered scan multiplexer.
module seven_seg_bank
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  BLANK_LZ,
  input  logic [DIGITS-1:0]     BLINK_MASK,
  output logic                  ACK,
  output logic [7*DIGITS-1:0]   DISP,
  output logic [6:0]            SCAN_SEG,
  output logic [DIGITS-1:0]     SCAN_SEL
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam seg_t               BLANK      = (ACTIVE_LOW != 0) ? SEG_BLANK_AL : ~SEG_BLANK_AL;

  function automatic logic [DIGITS-1:0] sel_code(input logic [IDX_W-1:0] idx);
    logic [DIGITS-1:0] onehot;
    onehot = DIGITS'(1) << idx;
    return (ACTIVE_LOW != 0) ? ~onehot : onehot;
  endfunction

  logic [4*DIGITS-1:0]    value_p0;
  logic                   vld_p0;
  logic [DIGITS-1:0][6:0] code_p0;
  logic [DIGITS-1:0]      blank_p0;
  logic [DIGITS-1:0][6:0] disp_p1;
  logic [6:0]             scan_seg_p2;
  logic [DIGITS-1:0]      scan_sel_p2;

  logic [BLINK_W-1:0]     blink_cnt;
  logic                   blink_phase;
  logic [SCAN_W-1:0]      scan_cnt;
  logic [IDX_W-1:0]       scan_idx;
  logic [IDX_W-1:0]       scan_idx_nxt;

  // Stage p0: capture the display value; ACK is the load strobe delayed one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      value_p0 <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= LOAD;
      if (LOAD) value_p0 <= VALUE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      scan_cnt    <= '0;
    end else begin
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_W'(1);
      if (blink_cnt == BLINK_LAST) blink_phase <= ~blink_phase;
      scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    scan_idx_nxt = scan_idx;
    if (scan_cnt == SCAN_LAST)
      scan_idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    hex_to_seg #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .nibble (value_p0[4*g +: 4]),
      .seg    (code_p0[g])
    );
  end

  // Walk from the most significant digit down, tracking whether everything above is zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_p0   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (value_p0[4*i +: 4] == 4'd0);
      blank_p0[i] = (BLANK_LZ & zero_above & (i != 0)) | (blink_phase & BLINK_MASK[i]);
    end
  end

  // Stage p1: registered static segment outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp_p1 <= {DIGITS{BLANK}};
    end else begin
      for (int i = 0; i < DIGITS; i++)
        disp_p1[i] <= blank_p0[i] ? BLANK : code_p0[i];
    end
  end

  // Stage p2: scan mux; select and segments update on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_idx    <= '0;
      scan_seg_p2 <= BLANK;
      scan_sel_p2 <= sel_code('0);
    end else begin
      scan_idx    <= scan_idx_nxt;
      scan_seg_p2 <= disp_p1[scan_idx_nxt];
      scan_sel_p2 <= sel_code(scan_idx_nxt);
    end
  end

  assign ACK      = vld_p0;
  assign DISP     = disp_p1;
  assign SCAN_SEG = scan_seg_p2;
  assign SCAN_SEL = scan_sel_p2;

endmodule

// File: tb/tb_seven_seg_bank.sv
// Self-checking bench for seven_seg_bank: vector table, directed corner
// sequences and a randomized run against a cycle-count based reference model.
module tb_seven_seg_bank;

  localparam int DIGITS    = 4;
  localparam int BLINK_DIV = 4;
  localparam int SCAN_DIV  = 3;
  localparam logic [6:0] BL = 7'b1111111;

  logic        CLK = 1'b0;
  logic        RST;
  logic        LOAD;
  logic [15:0] VALUE;
  logic        BLANK_LZ;
  logic [3:0]  BLINK_MASK;
  logic        ACK;
  logic [27:0] DISP;
  logic [6:0]  SCAN_SEG;
  logic [3:0]  SCAN_SEL;

  int errors = 0;
  int checks = 0;

  seven_seg_bank #(
    .DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .BLANK_LZ(BLANK_LZ),
    .BLINK_MASK(BLINK_MASK), .ACK(ACK), .DISP(DISP), .SCAN_SEG(SCAN_SEG),
    .SCAN_SEL(SCAN_SEL)
  );

  always #5 CLK = ~CLK;

  logic [6:0] code_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: blink phase and scan index follow from cycles since reset.
  logic [15:0] m_val;
  logic        m_ack;
  logic [6:0]  m_disp [4];
  logic [6:0]  m_seg;
  logic [3:0]  m_sel;
  int          t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_digit(input logic [15:0] v, input int i, input logic blz,
                                           input logic [3:0] mask, input logic phase);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = v >> (4 * i);
    nib   = upper[3:0];
    if (phase && mask[i]) return BL;
    if (blz && i > 0 && upper == 16'd0) return BL;
    return code_tab[nib];
  endfunction

  function automatic logic [27:0] model_disp();
    return {m_disp[3], m_disp[2], m_disp[1], m_disp[0]};
  endfunction

  task automatic step();
    logic [6:0] old_disp [4];
    int         idx_after;
    logic       phase_before;
    @(posedge CLK);
    #1;
    if (RST) begin
      m_val = '0;
      m_ack = 1'b0;
      for (int i = 0; i < 4; i++) m_disp[i] = BL;
      m_seg = BL;
      m_sel = 4'b1110;
      t     = 0;
    end else begin
      phase_before = ((t / BLINK_DIV) % 2) == 1;
      idx_after    = ((t + 1) / SCAN_DIV) % DIGITS;
      old_disp     = m_disp;
      for (int i = 0; i < 4; i++)
        m_disp[i] = ref_digit(m_val, i, BLANK_LZ, BLINK_MASK, phase_before);
      m_seg = old_disp[idx_after];
      m_sel = ~(4'b0001 << idx_after);
      m_ack = LOAD;
      if (LOAD) m_val = VALUE;
      t++;
    end
    chk("model_ack", 32'(ACK), 32'(m_ack));
    chk("model_disp", 32'(DISP), 32'(model_disp()));
    chk("model_scan_seg", 32'(SCAN_SEG), 32'(m_seg));
    chk("model_scan_sel", 32'(SCAN_SEL), 32'(m_sel));
  endtask

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [27:0] disp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [3:0] sel_seq [13];
    logic [6:0] prev_d0;
    int         toggles;

    vecs[0] = '{16'h12AF, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
    vecs[1] = '{16'h0040, 1'b1, {BL, BL, 7'b0011001, 7'b1000000}};
    vecs[2] = '{16'h0000, 1'b1, {BL, BL, BL, 7'b1000000}};
    vecs[3] = '{16'h0000, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[4] = '{16'h0100, 1'b1, {BL, 7'b1111001, 7'b1000000, 7'b1000000}};
    vecs[5] = '{16'hF000, 1'b1, {7'b0001110, 7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[6] = '{16'h3456, 1'b0, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
    vecs[7] = '{16'h789B, 1'b1, {7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011}};
    vecs[8] = '{16'hCDE0, 1'b1, {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}};

    RST = 1'b1; LOAD = 1'b0; VALUE = '0; BLANK_LZ = 1'b0; BLINK_MASK = '0;
    step();
    step();
    chk("reset_disp", 32'(DISP), 32'({4{BL}}));
    chk("reset_scan_seg", 32'(SCAN_SEG), 32'(BL));
    chk("reset_scan_sel", 32'(SCAN_SEL), 32'(4'b1110));
    chk("reset_ack", 32'(ACK), 32'(0));
    RST = 1'b0;

    // Table of load vectors with literal expected segment patterns.
    for (int v = 0; v < 9; v++) begin
      VALUE = vecs[v].value; BLANK_LZ = vecs[v].blz; LOAD = 1'b1;
      step();
      chk("load_ack", 32'(ACK), 32'(1));
      LOAD = 1'b0;
      step();
      chk("load_disp", 32'(DISP), 32'(vecs[v].disp));
      chk("ack_drop", 32'(ACK), 32'(0));
    end

    // Blink: only digit 0 flashes.
    VALUE = 16'h1111; BLANK_LZ = 1'b0; BLINK_MASK = 4'b0001; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    step();
    prev_d0 = DISP[6:0];
    toggles = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("blink_steady", 32'(DISP[27:7]), 32'({3{7'b1111001}}));
      if (DISP[6:0] != prev_d0) toggles++;
      prev_d0 = DISP[6:0];
    end
    checks++;
    if (toggles < 3 || toggles > 4) begin
      errors++;
      $display("FAIL blink_toggles: got %0d expected 3..4", toggles);
    end
    BLINK_MASK = '0;

    // RST wins over LOAD.
    RST = 1'b1; LOAD = 1'b1; VALUE = 16'h9999;
    step();
    chk("prio_ack", 32'(ACK), 32'(0));
    RST = 1'b0; LOAD = 1'b0;
    step();
    step();
    chk("prio_value", 32'(DISP), 32'({4{7'b1000000}}));

    // Repeated load with changing value.
    LOAD = 1'b1;
    VALUE = 16'h1234; step(); chk("rep_ack0", 32'(ACK), 32'(1));
    VALUE = 16'hABCD; step(); chk("rep_ack1", 32'(ACK), 32'(1));
    VALUE = 16'h3456; step(); chk("rep_ack2", 32'(ACK), 32'(1));
    LOAD = 1'b0;
    step();
    chk("rep_ack_off", 32'(ACK), 32'(0));
    chk("rep_disp", 32'(DISP), 32'(vecs[6].disp));

    // Mid-operation reset during blink phase 1 and scan index 2.
    RST = 1'b1; step(); RST = 1'b0;
    BLINK_MASK = 4'b1111;
    for (int k = 0; k < 6; k++) step();
    chk("pre_reset_sel", 32'(SCAN_SEL), 32'(4'b1011));
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("midrst_disp", 32'(DISP), 32'({4{BL}}));
    chk("midrst_sel", 32'(SCAN_SEL), 32'(4'b1110));
    sel_seq = '{4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101, 4'b1011,
                4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b1110};
    for (int k = 1; k < 13; k++) begin
      step();
      chk("scan_seq", 32'(SCAN_SEL), 32'(sel_seq[k]));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      RST        = ($urandom_range(0, 59) == 0);
      LOAD       = ($urandom_range(0, 3) == 0);
      VALUE      = 16'($urandom);
      if ($urandom_range(0, 1) == 0) VALUE = VALUE & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      BLANK_LZ   = 1'($urandom);
      BLINK_MASK = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
